// File: rtl/spi_engine.sv
// spi_engine: SPI master shift engine for the Gigatron expansion CPLD.
// A single START strobe runs one DW-bit transfer, MSB first. Slave select,
// SPI mode and the SCK half-period are captured with the word, so the
// operand registers can be rewritten while a transfer is in flight.
// With HOLD the select stays low across words until RELEASE or a
// transfer to another slave.
module spi_engine #(
    parameter  int NSS  = 2,
    parameter  int DW   = 8,
    parameter  int DIVW = 4,
    localparam int SW   = (NSS > 1) ? $clog2(NSS) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [DW-1:0]   WDATA,
    input  logic [SW-1:0]   SEL,
    input  logic            CPOL,
    input  logic            CPHA,
    input  logic            HOLD,
    input  logic [DIVW-1:0] DIV,
    input  logic            RELEASE,
    input  logic [NSS-1:0]  MISO,
    output logic            MOSI,
    output logic            SCK,
    output logic [NSS-1:0]  nSS,
    output logic [DW-1:0]   RDATA,
    output logic            BUSY,
    output logic            DONE
);

    localparam int BW = $clog2(DW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LEAD,
        S_TRAIL,
        S_DONE
    } state_t;

    // Transfer settings frozen at the accepted START.
    typedef struct packed {
        logic [SW-1:0]   sel;
        logic            cpol;
        logic            cpha;
        logic            hold;
        logic [DIVW-1:0] div;
    } cfg_t;

    state_t          state, state_nxt;
    cfg_t            cfg;
    logic [DIVW-1:0] cnt;
    logic [BW-1:0]   bitcnt;
    logic [DW-1:0]   shreg;
    logic            rxbit;
    logic            start_acc;
    logic            hp_zero;
    logic            miso_sel;
    logic [NSS-1:0]  cur_hit;
    logic [NSS-1:0]  new_hit;

    // Per-slave decode. An out-of-range select matches no slave, so nothing
    // is asserted and the sampled input reads as 0.
    for (genvar g = 0; g < NSS; g++) begin : g_slave
        assign cur_hit[g] = (cfg.sel == SW'(g));
        assign new_hit[g] = (SEL == SW'(g));
    end

    assign miso_sel  = |(MISO & cur_hit);
    assign start_acc = START && ((state == S_IDLE) || (state == S_DONE));
    assign hp_zero   = (cnt == '0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: each timed state leaves when the half-period count hits 0.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_acc) state_nxt = S_SETUP;
            S_SETUP: if (hp_zero) state_nxt = S_LEAD;
            S_LEAD:  if (hp_zero) state_nxt = S_TRAIL;
            S_TRAIL: if (hp_zero) state_nxt = (bitcnt == '0) ? S_DONE : S_LEAD;
            S_DONE:  state_nxt = start_acc ? S_SETUP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Half-period counter: reload on every state change, then count down to 0
    // and stay there, so a maximum DIV never wraps.
    always_ff @(posedge CLK) begin
        if (RST)                     cnt <= '0;
        else if (state_nxt != state) cnt <= start_acc ? DIV : cfg.div;
        else if (!hp_zero)           cnt <= cnt - DIVW'(1);
    end

    // Status flags, registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            BUSY <= (state_nxt == S_SETUP) || (state_nxt == S_LEAD) ||
                    (state_nxt == S_TRAIL);
            DONE <= (state_nxt == S_DONE);
        end
    end

    // Shift datapath and pin drivers; every action is tied to a state entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg    <= '0;
            shreg  <= '0;
            rxbit  <= 1'b0;
            bitcnt <= '0;
            MOSI   <= 1'b0;
            SCK    <= 1'b0;
            nSS    <= '1;
            RDATA  <= '0;
        end else if (start_acc) begin
            // Entering SETUP: the new select replaces any held one in the same
            // edge, so two selects are never low together.
            cfg    <= '{sel: SEL, cpol: CPOL, cpha: CPHA, hold: HOLD, div: DIV};
            shreg  <= WDATA;
            bitcnt <= BW'(DW - 1);
            nSS    <= ~new_hit;
            SCK    <= CPOL;
            if (!CPHA) MOSI <= WDATA[DW-1];
        end else begin
            if (((state == S_IDLE) || (state == S_DONE)) && RELEASE)
                nSS <= '1;

            // Leading SCK edge: mode-0/2 samples, mode-1/3 launches the MSB.
            if ((state != S_LEAD) && (state_nxt == S_LEAD)) begin
                SCK <= ~cfg.cpol;
                if (cfg.cpha) MOSI  <= shreg[DW-1];
                else          rxbit <= miso_sel;
            end

            // Trailing SCK edge: shift in the received bit. Mode-0/2 then
            // launches the next MSB, except after the last bit so MOSI holds.
            if ((state != S_TRAIL) && (state_nxt == S_TRAIL)) begin
                SCK <= cfg.cpol;
                if (cfg.cpha) begin
                    shreg <= {shreg[DW-2:0], miso_sel};
                end else begin
                    shreg <= {shreg[DW-2:0], rxbit};
                    if (bitcnt != '0) MOSI <= shreg[DW-2];
                end
            end

            if ((state == S_TRAIL) && (state_nxt == S_LEAD))
                bitcnt <= bitcnt - BW'(1);

            if ((state == S_TRAIL) && (state_nxt == S_DONE)) begin
                RDATA <= shreg;
                if (!cfg.hold) nSS <= '1;
            end
        end
    end

endmodule

// File: tb/tb_spi_engine.sv
// tb_spi_engine: scenario tasks for spi_engine. Expected receive words go
// into a queue when a transfer is started and are checked when DONE pulses.
// NSS=3 so that a 2-bit select can address a slave that does not exist.
module tb_spi_engine;

    localparam int NSS = 3;
    localparam int DW  = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] WDATA = '0;
    logic [1:0] SEL = '0;
    logic       CPOL = 1'b0;
    logic       CPHA = 1'b0;
    logic       HOLD = 1'b0;
    logic [3:0] DIV = '0;
    logic       RELEASE = 1'b0;
    logic [2:0] MISO;
    logic       MOSI;
    logic       SCK;
    logic [2:0] nSS;
    logic [7:0] RDATA;
    logic       BUSY;
    logic       DONE;

    logic       loop_en = 1'b0;
    logic [2:0] miso_drv = '0;
    logic       slv_en = 1'b0;
    logic [7:0] slv_pat = '0;
    int         slv_k = 0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    int m_sel, m_done_at, m_busy, m_rises, m_gap, m_selhi, m_multi, m_mosihi;

    assign MISO = {miso_drv[2], miso_drv[1], loop_en ? MOSI : miso_drv[0]};

    spi_engine #(.NSS(NSS), .DW(DW), .DIVW(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .WDATA(WDATA), .SEL(SEL),
        .CPOL(CPOL), .CPHA(CPHA), .HOLD(HOLD), .DIV(DIV), .RELEASE(RELEASE),
        .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .RDATA(RDATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Mode-3 slave on MISO[1]: launches the next bit on each falling SCK.
    always @(negedge SCK) begin
        if (slv_en && nSS[1] === 1'b0 && slv_k < 8) begin
            miso_drv[1] = slv_pat[7 - slv_k];
            slv_k++;
        end
    end

    // Scoreboard: every DONE must match the oldest outstanding word.
    always @(negedge CLK) begin
        if (!RST && DONE === 1'b1) begin
            logic [7:0] e;
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rdata_sb: unexpected DONE, rdata=%h", RDATA);
            end else begin
                e = exp_q.pop_front();
                if (RDATA !== e) begin
                    bad++;
                    $display("FAIL rdata_sb: got %h want %h", RDATA, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] wd, input logic [7:0] ex, input int sel,
                              input logic cpol, input logic cpha, input logic hold,
                              input logic [3:0] div, input logic rel);
        WDATA = wd; SEL = 2'(sel); CPOL = cpol; CPHA = cpha; HOLD = hold;
        DIV = div; RELEASE = rel; START = 1'b1; m_sel = sel;
        exp_q.push_back(ex);
        tick();
        START = 1'b0; RELEASE = 1'b0;
    endtask

    // Called in the first cycle after START; gathers timing and pin statistics.
    task automatic wait_done(input int bound);
        int cyc, t1;
        logic prev;
        m_busy = 0; m_rises = 0; m_gap = -1; m_selhi = 0; m_multi = 0; m_mosihi = 0;
        cyc = 1; t1 = -1; prev = SCK;
        while (DONE !== 1'b1 && cyc < bound) begin
            if (BUSY === 1'b1) m_busy++;
            if ($countones(~nSS) > 1) m_multi++;
            if (m_sel < NSS) begin
                if (nSS[m_sel] !== 1'b0) m_selhi++;
            end else if (nSS !== 3'b111) m_selhi++;
            if (MOSI === 1'b1) m_mosihi++;
            tick();
            cyc++;
            if (SCK !== prev) begin
                if (SCK === 1'b1) m_rises++;
                if (t1 < 0) t1 = cyc;
                else if (m_gap < 0) m_gap = cyc - t1;
            end
            prev = SCK;
        end
        m_done_at = cyc;
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: no DONE within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();
        total++;
        if ({nSS, SCK, MOSI, BUSY, DONE} !== {3'b111, 4'b0000}) begin
            bad++;
            $display("FAIL reset_pins: nss=%b sck=%b mosi=%b busy=%b done=%b want 111 0 0 0 0",
                     nSS, SCK, MOSI, BUSY, DONE);
        end
        total++;
        if (RDATA !== 8'h00) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 00", RDATA);
        end
    endtask

    task automatic test_abort();
        int d0;
        loop_en = 1'b1;
        start_xfer(8'hC3, 8'hC3, 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (4) tick();
        WDATA = 8'h00; SEL = 2'd1; START = 1'b1;
        tick();
        START = 1'b0;
        total++;
        if (BUSY !== 1'b1 || nSS !== 3'b110) begin
            bad++;
            $display("FAIL abort_ignore_start: busy=%b nss=%b want 1 110", BUSY, nSS);
        end
        repeat (4) tick();
        exp_q.delete();
        d0 = done_cnt;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if ({nSS, SCK, BUSY, DONE} !== {3'b111, 3'b000} || RDATA !== 8'h00) begin
            bad++;
            $display("FAIL abort_state: nss=%b sck=%b busy=%b done=%b rdata=%h want 111 0 0 0 00",
                     nSS, SCK, BUSY, DONE, RDATA);
        end
        repeat (40) tick();
        total++;
        if (done_cnt !== d0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: dones=%0d want %0d busy=%b", done_cnt - d0, 0, BUSY);
        end
    endtask

    task automatic test_mode0();
        loop_en = 1'b1;
        start_xfer(8'hA5, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        wait_done(200);
        total++;
        if (m_done_at != 18 || m_busy != 17 || m_rises != 8 || m_gap != 1) begin
            bad++;
            $display("FAIL mode0_timing: done_at=%0d busy=%0d rises=%0d gap=%0d want 18 17 8 1",
                     m_done_at, m_busy, m_rises, m_gap);
        end
        total++;
        if (nSS !== 3'b111 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL mode0_done_cycle: nss=%b busy=%b want 111 0", nSS, BUSY);
        end
        tick();
        total++;
        if (DONE !== 1'b0 || nSS !== 3'b111) begin
            bad++;
            $display("FAIL mode0_after: done=%b nss=%b want 0 111", DONE, nSS);
        end
    endtask

    task automatic test_mode3();
        loop_en = 1'b0;
        slv_pat = 8'h3C; slv_k = 0; slv_en = 1'b1; miso_drv[1] = 1'b0;
        start_xfer(8'h96, 8'h3C, 1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
        wait_done(500);
        slv_en = 1'b0;
        total++;
        if (m_done_at != 69 || m_busy != 68 || m_rises != 8 || m_gap != 4 || m_selhi != 0) begin
            bad++;
            $display("FAIL mode3_timing: done_at=%0d busy=%0d rises=%0d gap=%0d selhi=%0d want 69 68 8 4 0",
                     m_done_at, m_busy, m_rises, m_gap, m_selhi);
        end
        tick();
        total++;
        if (SCK !== 1'b1 || nSS !== 3'b111) begin
            bad++;
            $display("FAIL mode3_idle: sck=%b nss=%b want 1 111", SCK, nSS);
        end
    endtask

    task automatic test_back_to_back();
        loop_en = 1'b1;
        start_xfer(8'h01, 8'h01, 0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        wait_done(200);
        total++;
        if (nSS !== 3'b110) begin
            bad++;
            $display("FAIL hold_done_nss: got %b want 110", nSS);
        end
        start_xfer(8'h02, 8'h02, 0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        total++;
        if (BUSY !== 1'b1 || nSS !== 3'b110) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b nss=%b want 1 110", BUSY, nSS);
        end
        wait_done(200);
        total++;
        if (m_selhi != 0 || m_done_at != 18) begin
            bad++;
            $display("FAIL b2b_second: selhi=%0d done_at=%0d want 0 18", m_selhi, m_done_at);
        end
        tick();
        total++;
        if (nSS !== 3'b110) begin
            bad++;
            $display("FAIL hold_idle_nss: got %b want 110", nSS);
        end
        RELEASE = 1'b1;
        tick();
        RELEASE = 1'b0;
        total++;
        if (nSS !== 3'b111) begin
            bad++;
            $display("FAIL release_nss: got %b want 111", nSS);
        end
    endtask

    task automatic test_sel_switch();
        loop_en = 1'b1;
        start_xfer(8'h5A, 8'h5A, 0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        wait_done(200);
        tick();
        total++;
        if (nSS !== 3'b110) begin
            bad++;
            $display("FAIL switch_held: got %b want 110", nSS);
        end
        miso_drv[1] = 1'b1;
        start_xfer(8'h33, 8'hFF, 1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
        total++;
        if (nSS !== 3'b101) begin
            bad++;
            $display("FAIL switch_nss: got %b want 101", nSS);
        end
        tick();
        RELEASE = 1'b1;
        tick();
        RELEASE = 1'b0;
        total++;
        if (nSS !== 3'b101 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL release_busy: nss=%b busy=%b want 101 1", nSS, BUSY);
        end
        wait_done(200);
        total++;
        if (m_multi != 0 || nSS !== 3'b111) begin
            bad++;
            $display("FAIL switch_end: multi=%0d nss=%b want 0 111", m_multi, nSS);
        end
        miso_drv[1] = 1'b0;
    endtask

    task automatic test_bad_sel();
        loop_en = 1'b1;
        miso_drv = 3'b111;
        start_xfer(8'hFF, 8'h00, 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        wait_done(200);
        total++;
        if (m_selhi != 0 || m_mosihi == 0 || m_done_at != 18 || nSS !== 3'b111) begin
            bad++;
            $display("FAIL bad_sel: selhi=%0d mosihi=%0d done_at=%0d nss=%b want 0 >0 18 111",
                     m_selhi, m_mosihi, m_done_at, nSS);
        end
        miso_drv = 3'b000;
    endtask

    task automatic test_div_sweep();
        logic [1:0] modes[4] = '{2'b01, 2'b10, 2'b00, 2'b11};
        logic [3:0] divs[4]  = '{4'd0, 4'd2, 4'd15, 4'd1};
        logic [7:0] words[4] = '{8'hC6, 8'h3F, 8'h81, 8'hE7};
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_xfer(words[i], words[i], 0, modes[i][1], modes[i][0], 1'b0, divs[i], 1'b0);
            wait_done(1000);
            total++;
            if (m_busy != 17 * (int'(divs[i]) + 1) || m_gap != int'(divs[i]) + 1) begin
                bad++;
                $display("FAIL div_sweep[%0d]: busy=%0d gap=%0d want %0d %0d", i, m_busy, m_gap,
                         17 * (int'(divs[i]) + 1), int'(divs[i]) + 1);
            end
            tick();
            total++;
            if (SCK !== modes[i][1]) begin
                bad++;
                $display("FAIL div_idle_sck[%0d]: got %b want %b", i, SCK, modes[i][1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_sel_switch();
        test_bad_sel();
        test_div_sweep();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d words never completed", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
